fp_int_to_float_conv: RTL



---
 rtl/fp_conv_pkg.sv | 27 ++
 rtl/fp_round_inc.sv | 26 ++
 rtl/fp_int_to_float_conv.sv | 116 +++++++++++
 3 files changed

// File: rtl/fp_conv_pkg.sv
// Shared constants and types for the integer-to-float converter and the
// rounding logic reused further down the FP pipeline.
package fp_conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   localparam int         FP_BIAS  = 127;
   localparam logic [7:0] EXP_INIT = 8'(FP_BIAS + 31);

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fp32_t;

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision for a truncated mantissa given guard, sticky and
// lsb bits. Encodings 101-111 fall back to round-to-nearest-even.
module fp_round_inc
   import fp_conv_pkg::*;
(
   input  logic [2:0] rm,
   input  logic       sign,
   input  logic       lsb,
   input  logic       g,
   input  logic       s,
   output logic       inc
);

   always_comb begin
      // NOTE: assign a default before the case so no path leaves inc unassigned (no latch).
      inc = 1'b0;
      case (rm)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (g | s);
         RM_RUP:  inc = ~sign & (g | s);
         RM_RMM:  inc = g;
         default: inc = g & (s | lsb);
      endcase
   end

endmodule

// File: rtl/fp_int_to_float_conv.sv
// Multi-cycle int32/uint32 to IEEE-754 single converter: nibble/bit
// normalising shifter, exponent counter and a single rounding step.
module fp_int_to_float_conv
   import fp_conv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] int_in,
   input  logic        is_signed,
   input  logic [2:0]  rm,
   output logic        busy,
   output logic        done,
   output logic [31:0] conv_out,
   output logic        nx
);

   state_e      state_q, state_d;
   logic [31:0] mag_q, mag_d;
   logic [7:0]  exp_q, exp_d;
   logic        sign_q, sign_d;
   logic [2:0]  rm_q, rm_d;
   fp32_t       res_q, res_d;
   logic        nx_q, nx_d;

   logic        g, s, lsb, inc;
   logic [23:0] mant_sum;
   logic [7:0]  exp_rnd;

   assign g   = mag_q[7];
   assign s   = |mag_q[6:0];
   assign lsb = mag_q[8];

   fp_round_inc u_round_inc (
      .rm   (rm_q),
      .sign (sign_q),
      .lsb  (lsb),
      .g    (g),
      .s    (s),
      .inc  (inc)
   );

   // Carry out of the 23-bit mantissa leaves it zero and bumps the exponent.
   assign mant_sum = {1'b0, mag_q[30:8]} + 24'(inc);
   assign exp_rnd  = exp_q + 8'(mant_sum[23]);

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      rm_d    = rm_q;
      res_d   = res_q;
      nx_d    = nx_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               rm_d    = rm;
               sign_d  = is_signed & int_in[31];
               mag_d   = sign_d ? (~int_in + 32'd1) : int_in;
               exp_d   = EXP_INIT;
               state_d = NORM;
            end
         end
         NORM: begin
            if (mag_q == 32'd0) begin
               res_d   = '0;
               nx_d    = 1'b0;
               state_d = DONE;
            end else if (mag_q[31:28] == 4'd0) begin
               mag_d = mag_q << 4;
               exp_d = exp_q - 8'd4;
            end else if (!mag_q[31]) begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 8'd1;
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            res_d   = '{sign: sign_q, exp: exp_rnd, mant: mant_sum[22:0]};
            nx_d    = g | s;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mag_q   <= '0;
         exp_q   <= '0;
         sign_q  <= 1'b0;
         rm_q    <= '0;
         res_q   <= '0;
         nx_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         rm_q    <= rm_d;
         res_q   <= res_d;
         nx_q    <= nx_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign conv_out = res_q;
   assign nx       = nx_q;

endmodule
